vec_seq_decoder: RTL and testbench
==================================

VEC_SEQ_DECODER -- requirements
Module: vec_seq_decoder

Interface
REQ-001 Parameter LANES, default 16, total vector lanes (byte lanes of the 128-bit vector datapath).
REQ-002 Parameter LANES_PER_PASS, default 4, lanes processed per issued pass; PASSES = LANES/LANES_PER_PASS.
REQ-003 Port clk  in  1  sole clock, rising edge.
REQ-004 Port reset  in  1  asynchronous, active-high reset.
REQ-005 Port InstrValid  in  1  decode stage presents an instruction.
REQ-006 Port Opcode  in  6  instruction opcode.
REQ-007 Port Func  in  3  scalar arithmetic function field.
REQ-008 Port Stall  in  1  hazard-unit stall; freezes all state and outputs.
REQ-009 Port Flush  in  1  hazard-unit flush; kills the current instruction.
REQ-010 Port InstrReady  out  1  instruction accepted this cycle when InstrValid && InstrReady.
REQ-011 Port Ctrl  out  ctrl_t  registered bundle: RegW, RegWV, MemtoReg, MemW, MemSrc, MemData, MemDataV, VecData, Branch, ALUOp, ALUSrc (1 bit each), RegSrc[1:0], ImmSrc[1:0].
REQ-012 Port CtrlValid  out  1  Ctrl holds a live pass.
REQ-013 Port PassIdx  out  max(1,$clog2(PASSES))  index of current pass.
REQ-014 Port LaneMask  out  LANES  lanes enabled for current pass.
REQ-015 Port Busy  out  1  multi-pass sequence in progress; fetch/decode must hold.
REQ-016 Port Illegal  out  1  one-cycle pulse: accepted opcode unimplemented.

Function
REQ-017 Decode table (unlisted fields 0, never x): 000000 Func[1:0]=11 -> RegW, ALUOp, ALUSrc, ImmSrc=11; 000000 other -> RegW, ALUOp.
REQ-018 0010xx -> RegW, ALUOp, ALUSrc, ImmSrc=00; 011000 str -> MemW, ALUSrc, RegSrc=01; 011001 ldr -> RegW, MemtoReg, ALUSrc.
REQ-019 001100 beq / 001101 bgt -> Branch, ALUOp, RegSrc=01; 000100 b -> Branch, ImmSrc=01.
REQ-020 Vector class: 100000 -> RegWV, MemtoReg, ALUOp; 111000 strv -> MemW, MemSrc, ALUSrc, RegSrc=01; 111001 ldrv -> RegWV, MemtoReg, MemSrc, VecData, ALUSrc.
REQ-021 Any other opcode is illegal: accepted as a bubble (CtrlValid=0, Ctrl=0) with Illegal=1 for one cycle.
REQ-022 FSM states IDLE, SEQ; InstrReady = (state==IDLE) && !Stall && !Flush.
REQ-023 IDLE, accept: next cycle Ctrl=decode, CtrlValid=1, PassIdx=0; latency 1 cycle.
REQ-024 IDLE, accept of vector opcode with PASSES>1: go SEQ, Busy=1 from the cycle pass 0 is output.
REQ-025 SEQ: each non-stalled cycle advances PassIdx by 1, Ctrl held; after PassIdx=PASSES-1 is output, return IDLE, Busy=0 on that last-pass cycle.
REQ-026 LaneMask: vector pass -> LANES_PER_PASS ones starting at bit PassIdx*LANES_PER_PASS; scalar -> all zeros; CtrlValid=0 -> all zeros.
REQ-027 Scalar op or PASSES=1: single pass, Busy stays 0.
REQ-028 CtrlValid=0 (no accept, bubble) forces Ctrl=0, PassIdx=0.
REQ-029 Stall=1: state, counter, Ctrl, CtrlValid, LaneMask all hold; no accept.
REQ-030 Flush has priority over Stall: next cycle CtrlValid=0, Ctrl=0, Busy=0, Illegal=0, state IDLE, partial sequence abandoned.
REQ-031 LANES not divisible by LANES_PER_PASS, or LANES_PER_PASS>LANES, is an elaboration error.

Reset
REQ-032 While reset=1: state IDLE, Ctrl=0, CtrlValid=0, PassIdx=0, LaneMask=0, Busy=0, Illegal=0, asynchronously.
REQ-033 Reset mid-sequence abandons it; first accept possible on the first clk edge after reset deasserts.

Structure
REQ-034 Package vec_ctrl_pkg holds ctrl_t, opcode localparams, and state enum.
REQ-035 Sub-module ctrl_decode (combinational opcode/func -> ctrl_t, is_vec, illegal) instantiated once; sequencing and registers in vec_seq_decoder.

Verification (LANES=16, LANES_PER_PASS=4)
REQ-036 Opcode 000000 Func=011, valid -> next cycle RegW=1, ALUSrc=1, ImmSrc=11, LaneMask=0, Busy=0.
REQ-037 Opcode 111001 accepted -> 4 consecutive cycles PassIdx 0..3, LaneMask 000F,00F0,0F00,F000, Busy 1,1,1,0, InstrReady=0 during first 3.
REQ-038 Opcode 100000, Stall=1 during pass 1 for 2 cycles -> PassIdx=1, LaneMask=00F0 held 3 cycles, then passes 2,3.
REQ-039 Opcode 111000, Flush during pass 2 -> next cycle CtrlValid=0, Busy=0, InstrReady=1.
REQ-040 Opcode 010101 -> Illegal=1 one cycle, CtrlValid=0, Ctrl=0.
REQ-041 reset asserted mid-vector pass 2 -> all outputs 0 immediately, state IDLE; PASSES=1 build: vector op single cycle, Busy=0, LaneMask=FFFF.

Source files
------------

// File: rtl/vec_ctrl_pkg.sv
// Shared types and opcode constants for the vector sequencing decoder.
package vec_ctrl_pkg;

   // Control bundle handed to execute; field order is the packed bit order, MSB first.
   typedef struct packed {
      logic       RegW;
      logic       RegWV;
      logic       MemtoReg;
      logic       MemW;
      logic       MemSrc;
      logic       MemData;
      logic       MemDataV;
      logic       VecData;
      logic       Branch;
      logic       ALUOp;
      logic       ALUSrc;
      logic [1:0] RegSrc;
      logic [1:0] ImmSrc;
   } ctrl_t;

   // Scalar opcodes
   localparam logic [5:0] OP_ALU     = 6'b000000;
   localparam logic [3:0] OP_IMM_PFX = 4'b0010;    // 0010xx immediate arithmetic
   localparam logic [5:0] OP_STR     = 6'b011000;
   localparam logic [5:0] OP_LDR     = 6'b011001;
   localparam logic [5:0] OP_BEQ     = 6'b001100;
   localparam logic [5:0] OP_BGT     = 6'b001101;
   localparam logic [5:0] OP_B       = 6'b000100;

   // Vector opcodes (multi-pass)
   localparam logic [5:0] OP_VALU    = 6'b100000;
   localparam logic [5:0] OP_STRV    = 6'b111000;
   localparam logic [5:0] OP_LDRV    = 6'b111001;

   typedef enum logic {
      IDLE = 1'b0,
      SEQ  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/func decode into the control bundle plus class flags.
module ctrl_decode
   import vec_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [2:0] func,
   output ctrl_t      ctrl,
   output logic       isVec,
   output logic       illegal
);

   // Func[2] carries no meaning for the decode table.
   logic unusedFuncHi;
   assign unusedFuncHi = func[2];

   // Table decode; every field defaults to 0 so nothing is left undefined.
   always_comb begin
      ctrl    = '0;
      isVec   = 1'b0;
      illegal = 1'b0;
      if (opcode[5:2] == OP_IMM_PFX) begin
         ctrl.RegW   = 1'b1;
         ctrl.ALUOp  = 1'b1;
         ctrl.ALUSrc = 1'b1;
         ctrl.ImmSrc = 2'b00;
      end else begin
         case (opcode)
            OP_ALU: begin
               ctrl.RegW  = 1'b1;
               ctrl.ALUOp = 1'b1;
               if (func[1:0] == 2'b11) begin
                  ctrl.ALUSrc = 1'b1;
                  ctrl.ImmSrc = 2'b11;
               end
            end
            OP_STR: begin
               ctrl.MemW   = 1'b1;
               ctrl.ALUSrc = 1'b1;
               ctrl.RegSrc = 2'b01;
            end
            OP_LDR: begin
               ctrl.RegW     = 1'b1;
               ctrl.MemtoReg = 1'b1;
               ctrl.ALUSrc   = 1'b1;
            end
            OP_BEQ, OP_BGT: begin
               ctrl.Branch = 1'b1;
               ctrl.ALUOp  = 1'b1;
               ctrl.RegSrc = 2'b01;
            end
            OP_B: begin
               ctrl.Branch = 1'b1;
               ctrl.ImmSrc = 2'b01;
            end
            OP_VALU: begin
               isVec         = 1'b1;
               ctrl.RegWV    = 1'b1;
               ctrl.MemtoReg = 1'b1;
               ctrl.ALUOp    = 1'b1;
            end
            OP_STRV: begin
               isVec       = 1'b1;
               ctrl.MemW   = 1'b1;
               ctrl.MemSrc = 1'b1;
               ctrl.ALUSrc = 1'b1;
               ctrl.RegSrc = 2'b01;
            end
            OP_LDRV: begin
               isVec         = 1'b1;
               ctrl.RegWV    = 1'b1;
               ctrl.MemtoReg = 1'b1;
               ctrl.MemSrc   = 1'b1;
               ctrl.VecData  = 1'b1;
               ctrl.ALUSrc   = 1'b1;
            end
            default: illegal = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/vec_seq_decoder.sv
// Decode stage that issues vector ops as LANES/LANES_PER_PASS sequential passes.
module vec_seq_decoder
   import vec_ctrl_pkg::*;
#(
   parameter  int LANES          = 16,
   parameter  int LANES_PER_PASS = 4,
   localparam int PASSES         = LANES / LANES_PER_PASS,
   localparam int PIW            = (PASSES > 1) ? $clog2(PASSES) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InstrValid,
   input  logic [5:0]       Opcode,
   input  logic [2:0]       Func,
   input  logic             Stall,
   input  logic             Flush,
   output logic             InstrReady,
   output ctrl_t            Ctrl,
   output logic             CtrlValid,
   output logic [PIW-1:0]   PassIdx,
   output logic [LANES-1:0] LaneMask,
   output logic             Busy,
   output logic             Illegal
);

   if ((LANES_PER_PASS < 1) || (LANES_PER_PASS > LANES) || ((LANES % LANES_PER_PASS) != 0)) begin : gBadCfg
      $error("vec_seq_decoder: LANES must be a positive multiple of LANES_PER_PASS");
   end

   // Pass index at which SEQ hands back to IDLE (the next output is the final pass).
   localparam logic [PIW-1:0] PENULT = PIW'(PASSES - 2);

   seq_state_t     stateQ, stateD;
   ctrl_t          ctrlQ, ctrlD;
   logic           validQ, validD;
   logic           vecQ, vecD;
   logic           illQ, illD;
   logic [PIW-1:0] passQ, passD;

   ctrl_t decCtrl;
   logic  decVec;
   logic  decIll;

   ctrl_decode uDecode (
      .opcode  (Opcode),
      .func    (Func),
      .ctrl    (decCtrl),
      .isVec   (decVec),
      .illegal (decIll)
   );

   assign InstrReady = (stateQ == IDLE) && !Stall && !Flush;

   // Next-state: flush beats stall; stall freezes everything (Illegal included).
   always_comb begin
      stateD = stateQ;
      ctrlD  = ctrlQ;
      validD = validQ;
      vecD   = vecQ;
      illD   = illQ;
      passD  = passQ;
      if (Flush) begin
         stateD = IDLE;
         ctrlD  = '0;
         validD = 1'b0;
         vecD   = 1'b0;
         illD   = 1'b0;
         passD  = '0;
      end else if (!Stall) begin
         illD = 1'b0;
         case (stateQ)
            IDLE: begin
               // Default to a bubble; overwritten by a legal accept.
               ctrlD  = '0;
               validD = 1'b0;
               vecD   = 1'b0;
               passD  = '0;
               if (InstrValid) begin
                  if (decIll) begin
                     illD = 1'b1;
                  end else begin
                     ctrlD  = decCtrl;
                     validD = 1'b1;
                     vecD   = decVec;
                     if (decVec && (PASSES > 1)) stateD = SEQ;
                  end
               end
            end
            SEQ: begin
               passD = passQ + PIW'(1);
               if (passQ == PENULT) stateD = IDLE;
            end
            default: stateD = IDLE;
         endcase
      end
   end

   // State and output registers, cleared asynchronously on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stateQ <= IDLE;
         ctrlQ  <= '0;
         validQ <= 1'b0;
         vecQ   <= 1'b0;
         illQ   <= 1'b0;
         passQ  <= '0;
      end else begin
         stateQ <= stateD;
         ctrlQ  <= ctrlD;
         validQ <= validD;
         vecQ   <= vecD;
         illQ   <= illD;
         passQ  <= passD;
      end
   end

   // Each lane is enabled when its pass group matches the current pass of a vector op.
   for (genvar l = 0; l < LANES; l++) begin : gLane
      assign LaneMask[l] = validQ && vecQ && (passQ == PIW'(l / LANES_PER_PASS));
   end

   assign Ctrl      = ctrlQ;
   assign CtrlValid = validQ;
   assign PassIdx   = passQ;
   assign Busy      = (stateQ == SEQ);
   assign Illegal   = illQ;

endmodule

// File: tb/tb_vec_seq_decoder.sv
// Bench: two builds (4 passes and 1 pass) against a pass-count reference model.
module tb_vec_seq_decoder;
   import vec_ctrl_pkg::*;

   logic       clk;
   logic       reset;
   logic       InstrValid;
   logic [5:0] Opcode;
   logic [2:0] Func;
   logic       Stall;
   logic       Flush;

   logic        ready0, valid0, busy0, ill0;
   ctrl_t       ctrl0;
   logic [1:0]  pass0;
   logic [15:0] mask0;
   logic        ready1, valid1, busy1, ill1;
   ctrl_t       ctrl1;
   logic [0:0]  pass1;
   logic [15:0] mask1;

   int nTests = 0;
   int nFail  = 0;

   vec_seq_decoder #(.LANES(16), .LANES_PER_PASS(4)) dut (
      .clk(clk), .reset(reset), .InstrValid(InstrValid), .Opcode(Opcode), .Func(Func),
      .Stall(Stall), .Flush(Flush), .InstrReady(ready0), .Ctrl(ctrl0), .CtrlValid(valid0),
      .PassIdx(pass0), .LaneMask(mask0), .Busy(busy0), .Illegal(ill0));

   vec_seq_decoder #(.LANES(16), .LANES_PER_PASS(16)) dut1 (
      .clk(clk), .reset(reset), .InstrValid(InstrValid), .Opcode(Opcode), .Func(Func),
      .Stall(Stall), .Flush(Flush), .InstrReady(ready1), .Ctrl(ctrl1), .CtrlValid(valid1),
      .PassIdx(pass1), .LaneMask(mask1), .Busy(busy1), .Illegal(ill1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model per build: the currently shown pass plus how many passes remain.
   logic        mValid [2];
   logic [14:0] mCtrl  [2];
   logic        mVec   [2];
   logic        mIll   [2];
   int          mPass  [2];
   int          mRem   [2];

   function automatic int passesOf(int d);
      return (d == 0) ? 4 : 1;
   endfunction

   function automatic int lppOf(int d);
      return (d == 0) ? 4 : 16;
   endfunction

   function automatic logic [15:0] maskOf(int lpp, int k);
      logic [31:0] m;
      m = ((32'd1 << lpp) - 32'd1) << (k * lpp);
      return m[15:0];
   endfunction

   // {illegal, vector, RegW RegWV MemtoReg MemW MemSrc MemData MemDataV VecData Branch ALUOp ALUSrc RegSrc[1:0] ImmSrc[1:0]}
   function automatic logic [16:0] refDecode(logic [5:0] op, logic [2:0] fn);
      casez (op)
         6'b000000: return (fn[1:0] == 2'b11) ? {2'b00, 15'h4033} : {2'b00, 15'h4020};
         6'b0010??: return {2'b00, 15'h4030};
         6'b011000: return {2'b00, 15'h0814};
         6'b011001: return {2'b00, 15'h5010};
         6'b001100: return {2'b00, 15'h0064};
         6'b001101: return {2'b00, 15'h0064};
         6'b000100: return {2'b00, 15'h0041};
         6'b100000: return {2'b01, 15'h3020};
         6'b111000: return {2'b01, 15'h0C14};
         6'b111001: return {2'b01, 15'h3490};
         default:   return {2'b10, 15'h0000};
      endcase
   endfunction

   task automatic mClear(int d);
      mValid[d] = 1'b0;
      mCtrl[d]  = '0;
      mVec[d]   = 1'b0;
      mIll[d]   = 1'b0;
      mPass[d]  = 0;
      mRem[d]   = 0;
   endtask

   task automatic mStep(int d);
      logic [16:0] dec;
      if (Flush) begin
         mClear(d);
      end else if (!Stall) begin
         if (mRem[d] > 0) begin
            mPass[d] = mPass[d] + 1;
            mRem[d]  = mRem[d] - 1;
            mIll[d]  = 1'b0;
         end else begin
            mClear(d);
            if (InstrValid) begin
               dec = refDecode(Opcode, Func);
               if (dec[16]) begin
                  mIll[d] = 1'b1;
               end else begin
                  mValid[d] = 1'b1;
                  mCtrl[d]  = dec[14:0];
                  mVec[d]   = dec[15];
                  mRem[d]   = dec[15] ? passesOf(d) - 1 : 0;
               end
            end
         end
      end
   endtask

   initial begin
      mClear(0);
      mClear(1);
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            mClear(0);
            mClear(1);
         end else begin
            mStep(0);
            mStep(1);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmpBuild(input int d, input logic valid, input logic [14:0] ctrl, input int pass,
                           input logic [15:0] mask, input logic busy, input logic ill, input logic ready);
      logic [15:0] eMask;
      eMask = (mValid[d] && mVec[d]) ? maskOf(lppOf(d), mPass[d]) : 16'h0;
      chk($sformatf("b%0d CtrlValid", d), {31'd0, valid}, {31'd0, mValid[d]});
      chk($sformatf("b%0d Ctrl", d), {17'd0, ctrl}, {17'd0, mCtrl[d]});
      chk($sformatf("b%0d PassIdx", d), pass, mPass[d]);
      chk($sformatf("b%0d LaneMask", d), {16'd0, mask}, {16'd0, eMask});
      chk($sformatf("b%0d Busy", d), {31'd0, busy}, {31'd0, mRem[d] > 0});
      chk($sformatf("b%0d Illegal", d), {31'd0, ill}, {31'd0, mIll[d]});
      chk($sformatf("b%0d InstrReady", d), {31'd0, ready},
          {31'd0, (mRem[d] == 0) && !Stall && !Flush});
   endtask

   // Drive one cycle of inputs away from the active edge, then compare both builds to the model.
   task automatic step(input logic v, input logic [5:0] op, input logic [2:0] fn,
                       input logic st, input logic fl, input logic rs);
      @(negedge clk);
      InstrValid = v;
      Opcode     = op;
      Func       = fn;
      Stall      = st;
      Flush      = fl;
      reset      = rs;
      #1;
      cmpBuild(0, valid0, ctrl0, int'(pass0), mask0, busy0, ill0, ready0);
      cmpBuild(1, valid1, ctrl1, int'(pass1), mask1, busy1, ill1, ready1);
   endtask

   task automatic idle();
      step(1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b0);
   endtask

   logic [5:0]  pool [0:12];
   logic [15:0] eMask37 [0:3];
   logic [3:0]  eBusy37;
   logic [3:0]  eRdy37;

   initial begin
      pool[0] = 6'b000000; pool[1] = 6'b001000; pool[2] = 6'b001011; pool[3] = 6'b011000;
      pool[4] = 6'b011001; pool[5] = 6'b001100; pool[6] = 6'b001101; pool[7] = 6'b000100;
      pool[8] = 6'b100000; pool[9] = 6'b111000; pool[10] = 6'b111001; pool[11] = 6'b111001;
      pool[12] = 6'b010101;
      eMask37[0] = 16'h000F; eMask37[1] = 16'h00F0; eMask37[2] = 16'h0F00; eMask37[3] = 16'hF000;
      eBusy37 = 4'b0111;   // bit k = Busy expected on pass k
      eRdy37  = 4'b1000;

      reset = 1'b1; InstrValid = 1'b0; Opcode = '0; Func = '0; Stall = 1'b0; Flush = 1'b0;

      // Reset state
      step(1'b1, 6'b111001, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("rst CtrlValid", {31'd0, valid0}, 32'd0);
      chk("rst LaneMask", {16'd0, mask0}, 32'd0);
      chk("rst Busy", {31'd0, busy0}, 32'd0);
      idle();

      // Scalar immediate-form ALU op
      step(1'b1, 6'b000000, 3'b011, 1'b0, 1'b0, 1'b0);
      idle();
      chk("alu Ctrl", {17'd0, ctrl0}, 32'h4033);
      chk("alu CtrlValid", {31'd0, valid0}, 32'd1);
      chk("alu LaneMask", {16'd0, mask0}, 32'd0);
      chk("alu Busy", {31'd0, busy0}, 32'd0);

      // ldrv: four passes, and a single full-width pass on the 1-pass build
      step(1'b1, 6'b111001, 3'd0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         idle();
         chk($sformatf("ldrv p%0d PassIdx", k), {30'd0, pass0}, k);
         chk($sformatf("ldrv p%0d LaneMask", k), {16'd0, mask0}, {16'd0, eMask37[k]});
         chk($sformatf("ldrv p%0d Busy", k), {31'd0, busy0}, {31'd0, eBusy37[k]});
         chk($sformatf("ldrv p%0d InstrReady", k), {31'd0, ready0}, {31'd0, eRdy37[k]});
         if (k == 0) begin
            chk("1pass LaneMask", {16'd0, mask1}, 32'hFFFF);
            chk("1pass Busy", {31'd0, busy1}, 32'd0);
            chk("1pass CtrlValid", {31'd0, valid1}, 32'd1);
         end
      end

      // Vector ALU with a two-cycle stall on pass 1
      step(1'b1, 6'b100000, 3'd0, 1'b0, 1'b0, 1'b0);
      idle();
      step(1'b0, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("stall a PassIdx", {30'd0, pass0}, 32'd1);
      step(1'b0, 6'd0, 3'd0, 1'b1, 1'b0, 1'b0);
      chk("stall b LaneMask", {16'd0, mask0}, 32'h00F0);
      idle();
      chk("stall c PassIdx", {30'd0, pass0}, 32'd1);
      chk("stall c LaneMask", {16'd0, mask0}, 32'h00F0);
      idle();
      chk("stall p2 PassIdx", {30'd0, pass0}, 32'd2);
      idle();
      chk("stall p3 PassIdx", {30'd0, pass0}, 32'd3);

      // strv flushed during pass 2
      step(1'b1, 6'b111000, 3'd0, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      step(1'b0, 6'd0, 3'd0, 1'b0, 1'b1, 1'b0);
      chk("flush at p2", {30'd0, pass0}, 32'd2);
      idle();
      chk("flush CtrlValid", {31'd0, valid0}, 32'd0);
      chk("flush Busy", {31'd0, busy0}, 32'd0);
      chk("flush InstrReady", {31'd0, ready0}, 32'd1);

      // Unimplemented opcode
      step(1'b1, 6'b010101, 3'd0, 1'b0, 1'b0, 1'b0);
      idle();
      chk("illegal pulse", {31'd0, ill0}, 32'd1);
      chk("illegal Ctrl", {17'd0, ctrl0}, 32'd0);
      chk("illegal CtrlValid", {31'd0, valid0}, 32'd0);
      idle();
      chk("illegal cleared", {31'd0, ill0}, 32'd0);

      // Reset in the middle of pass 2, then accept on the first edge afterwards
      step(1'b1, 6'b111001, 3'd0, 1'b0, 1'b0, 1'b0);
      idle();
      idle();
      idle();
      chk("pre-reset PassIdx", {30'd0, pass0}, 32'd2);
      step(1'b0, 6'd0, 3'd0, 1'b0, 1'b0, 1'b1);
      chk("midrst CtrlValid", {31'd0, valid0}, 32'd0);
      chk("midrst Busy", {31'd0, busy0}, 32'd0);
      chk("midrst LaneMask", {16'd0, mask0}, 32'd0);
      chk("midrst PassIdx", {30'd0, pass0}, 32'd0);
      step(1'b1, 6'b100000, 3'd0, 1'b0, 1'b0, 1'b0);
      idle();
      chk("post-rst accept", {31'd0, valid0}, 32'd1);
      chk("post-rst Busy", {31'd0, busy0}, 32'd1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : pool[$urandom_range(0, 12)];
         step($urandom_range(0, 9) < 7, op, 3'($urandom),
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
              $urandom_range(0, 299) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
